// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 stream demultiplexer.
//
// Contents:
//   NUM_OUT      - number of output channels
//   SEL_W        - width of the channel select
//   chan_idx_t   - channel index type
//   slot_state_e - occupancy state of a one-entry output slot
package demux_pkg;

  localparam int NUM_OUT = 4;
  localparam int SEL_W   = 2;

  typedef logic [SEL_W-1:0] chan_idx_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage : demux_pkg

// File: rtl/demux_slot.sv
// One-entry output slot: a data register with a valid/ready drain handshake.
//
// Ports:
//   clk      - clock, rising edge
//   reset    - synchronous active-high reset; empties the slot and zeroes q
//   load     - write d into the slot at the next edge (slot becomes FULL)
//   d        - data to load
//   q        - held data; keeps its last value while the slot is EMPTY
//   valid    - slot is FULL
//   ready    - consumer takes the held word this cycle
//   can_load - a load this cycle will not overwrite an untaken word
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  input  logic             ready,
  output logic             can_load
);

  slot_state_e state, state_next;

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SLOT_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // A load wins over a drain in the same cycle, so a slot being emptied and
  // refilled at once stays FULL and carries the new word.
  always_comb begin
    state_next = state;
    case (state)
      SLOT_EMPTY: begin
        if (load) state_next = SLOT_FULL;
      end
      SLOT_FULL: begin
        if (load)       state_next = SLOT_FULL;
        else if (ready) state_next = SLOT_EMPTY;
      end
      default: state_next = SLOT_EMPTY;
    endcase
  end

  // Data register: only a load changes it, so the last word stays visible
  // after it has been drained.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

  assign valid    = (state == SLOT_FULL);
  assign can_load = (state == SLOT_EMPTY) || ready;

endmodule : demux_slot

// File: rtl/demux4_stream.sv
// Registered 1-to-4 stream demultiplexer. Each input word is routed by sel
// into one of four one-entry slots, each with its own valid/ready handshake.
//
// Ports:
//   clk         - clock, rising edge
//   reset       - synchronous active-high reset; discards all held words
//   din, sel    - input word and its destination channel
//   in_valid    - producer presents din/sel
//   in_ready    - the selected slot can take din this cycle
//   dout_0..3   - registered channel data
//   out_valid   - bit i: channel i holds a word
//   out_ready   - bit i: consumer i takes its word this cycle
//   busy        - at least one channel holds a word
//   xfer_cnt    - number of accepted input words, wrapping
module demux4_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   din,
  input  chan_idx_t          sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   dout_0,
  output logic [WIDTH-1:0]   dout_1,
  output logic [WIDTH-1:0]   dout_2,
  output logic [WIDTH-1:0]   dout_3,
  output logic [NUM_OUT-1:0] out_valid,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic               busy,
  output logic [CNT_W-1:0]   xfer_cnt
);

  logic [NUM_OUT-1:0] load;
  logic [NUM_OUT-1:0] can_load;
  logic [WIDTH-1:0]   slot_q [NUM_OUT];
  logic               accept;

  // in_ready looks only at the currently selected slot, so a stalled
  // producer that switches sel is re-evaluated immediately, and a slot being
  // drained this cycle can be refilled in the same cycle.
  assign in_ready = !reset && can_load[sel];
  assign accept   = in_valid && in_ready;

  // Decode the accepted word into a single load strobe.
  always_comb begin
    load = '0;
    if (accept) load[sel] = 1'b1;
  end

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk      (clk),
      .reset    (reset),
      .load     (load[i]),
      .d        (din),
      .q        (slot_q[i]),
      .valid    (out_valid[i]),
      .ready    (out_ready[i]),
      .can_load (can_load[i])
    );
  end

  assign dout_0 = slot_q[0];
  assign dout_1 = slot_q[1];
  assign dout_2 = slot_q[2];
  assign dout_3 = slot_q[3];

  assign busy = |out_valid;

  // Accepted-word counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      xfer_cnt <= '0;
    end else if (accept) begin
      xfer_cnt <= xfer_cnt + CNT_W'(1);
    end
  end

endmodule : demux4_stream

// File: tb/tb_demux4_stream.sv
// Self-checking bench for demux4_stream. A default-width instance and a
// CNT_W=4 instance share the same stimulus; the narrow one exercises counter
// wrap.
module tb_demux4_stream;

  import demux_pkg::*;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] din;
  chan_idx_t        sel;
  logic             in_valid;
  logic [3:0]       out_ready;

  logic             in_ready,  in_ready_n;
  logic [WIDTH-1:0] dout_0, dout_1, dout_2, dout_3;
  logic [WIDTH-1:0] nd_0, nd_1, nd_2, nd_3;
  logic [3:0]       out_valid, out_valid_n;
  logic             busy, busy_n;
  logic [15:0]      xfer_cnt;
  logic [3:0]       xfer_cnt_n;

  logic [3:0][WIDTH-1:0] dout_all;
  assign dout_all = {dout_3, dout_2, dout_1, dout_0};

  int check_count = 0;
  int error_count = 0;

  demux4_stream #(.WIDTH(WIDTH), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .din(din), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .dout_0(dout_0), .dout_1(dout_1), .dout_2(dout_2),
    .dout_3(dout_3), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .xfer_cnt(xfer_cnt)
  );

  demux4_stream #(.WIDTH(WIDTH), .CNT_W(4)) dut_narrow (
    .clk(clk), .reset(reset), .din(din), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready_n), .dout_0(nd_0), .dout_1(nd_1), .dout_2(nd_2),
    .dout_3(nd_3), .out_valid(out_valid_n), .out_ready(out_ready),
    .busy(busy_n), .xfer_cnt(xfer_cnt_n)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic                  rst;
    logic                  iv;
    logic [1:0]            s;
    logic [7:0]            d;
    logic [3:0]            ordy;
    logic                  exp_rdy;
    logic [3:0]            exp_ov;
    logic [3:0][7:0]       exp_dout;
    logic [15:0]           exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic iv, logic [1:0] s, logic [7:0] d,
                              logic [3:0] ordy, logic exp_rdy, logic [3:0] exp_ov,
                              logic [3:0][7:0] exp_dout, logic [15:0] exp_cnt);
    vec_t v;
    v.rst = rst; v.iv = iv; v.s = s; v.d = d; v.ordy = ordy;
    v.exp_rdy = exp_rdy; v.exp_ov = exp_ov; v.exp_dout = exp_dout;
    v.exp_cnt = exp_cnt;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive at the falling edge, check in_ready mid-cycle, then check the
  // registered outputs just after the next rising edge.
  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk);
    reset     = v.rst;
    in_valid  = v.iv;
    sel       = v.s;
    din       = v.d;
    out_ready = v.ordy;
    #1;
    checkOutput($sformatf("v%0d in_ready", idx), {31'd0, in_ready}, {31'd0, v.exp_rdy});
    checkOutput($sformatf("v%0d in_ready_n", idx), {31'd0, in_ready_n}, {31'd0, v.exp_rdy});
    @(posedge clk);
    #1;
    checkOutput($sformatf("v%0d out_valid", idx), {28'd0, out_valid}, {28'd0, v.exp_ov});
    checkOutput($sformatf("v%0d dout", idx), dout_all, v.exp_dout);
    checkOutput($sformatf("v%0d busy", idx), {31'd0, busy}, {31'd0, |v.exp_ov});
    checkOutput($sformatf("v%0d xfer_cnt", idx), {16'd0, xfer_cnt}, {16'd0, v.exp_cnt});
    checkOutput($sformatf("v%0d xfer_cnt_n", idx), {28'd0, xfer_cnt_n}, {28'd0, v.exp_cnt[3:0]});
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; sel = '0; din = '0; out_ready = '0;

    // rst iv sel din ordy | rdy ov dout{3,2,1,0} cnt
    vecs.push_back(mk(1, 0, 0, 8'h00, 4'b0000, 0, 4'b0000, {8'h00, 8'h00, 8'h00, 8'h00}, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 4'b0000, 1, 4'b0000, {8'h00, 8'h00, 8'h00, 8'h00}, 0));
    // streaming, all consumers ready
    vecs.push_back(mk(0, 1, 0, 8'hA0, 4'b1111, 1, 4'b0001, {8'h00, 8'h00, 8'h00, 8'hA0}, 1));
    vecs.push_back(mk(0, 1, 1, 8'hA1, 4'b1111, 1, 4'b0010, {8'h00, 8'h00, 8'hA1, 8'hA0}, 2));
    vecs.push_back(mk(0, 1, 2, 8'hA2, 4'b1111, 1, 4'b0100, {8'h00, 8'hA2, 8'hA1, 8'hA0}, 3));
    vecs.push_back(mk(0, 1, 3, 8'hA3, 4'b1111, 1, 4'b1000, {8'hA3, 8'hA2, 8'hA1, 8'hA0}, 4));
    vecs.push_back(mk(0, 0, 0, 8'h00, 4'b1111, 1, 4'b0000, {8'hA3, 8'hA2, 8'hA1, 8'hA0}, 4));
    // back-pressure on channel 2, then release refills in the same cycle
    vecs.push_back(mk(0, 1, 2, 8'h55, 4'b1011, 1, 4'b0100, {8'hA3, 8'h55, 8'hA1, 8'hA0}, 5));
    vecs.push_back(mk(0, 1, 2, 8'h66, 4'b1011, 0, 4'b0100, {8'hA3, 8'h55, 8'hA1, 8'hA0}, 5));
    vecs.push_back(mk(0, 1, 2, 8'h66, 4'b1111, 1, 4'b0100, {8'hA3, 8'h66, 8'hA1, 8'hA0}, 6));
    vecs.push_back(mk(0, 0, 2, 8'h00, 4'b1111, 1, 4'b0000, {8'hA3, 8'h66, 8'hA1, 8'hA0}, 6));
    // stall on channel 1, switch sel to empty channel 3
    vecs.push_back(mk(0, 1, 1, 8'h77, 4'b0000, 1, 4'b0010, {8'hA3, 8'h66, 8'h77, 8'hA0}, 7));
    vecs.push_back(mk(0, 1, 1, 8'h88, 4'b0000, 0, 4'b0010, {8'hA3, 8'h66, 8'h77, 8'hA0}, 7));
    vecs.push_back(mk(0, 1, 3, 8'h88, 4'b0000, 1, 4'b1010, {8'h88, 8'h66, 8'h77, 8'hA0}, 8));
    vecs.push_back(mk(0, 0, 1, 8'hFF, 4'b0000, 0, 4'b1010, {8'h88, 8'h66, 8'h77, 8'hA0}, 8));
    // fill everything, then drain all four while reloading channel 0
    vecs.push_back(mk(0, 1, 0, 8'hC0, 4'b0000, 1, 4'b1011, {8'h88, 8'h66, 8'h77, 8'hC0}, 9));
    vecs.push_back(mk(0, 1, 2, 8'hC2, 4'b0000, 1, 4'b1111, {8'h88, 8'hC2, 8'h77, 8'hC0}, 10));
    vecs.push_back(mk(0, 1, 0, 8'hDD, 4'b0000, 0, 4'b1111, {8'h88, 8'hC2, 8'h77, 8'hC0}, 10));
    vecs.push_back(mk(0, 1, 0, 8'hE0, 4'b1111, 1, 4'b0001, {8'h88, 8'hC2, 8'h77, 8'hE0}, 11));
    // refill all slots, then reset mid-transfer
    vecs.push_back(mk(0, 1, 1, 8'hE1, 4'b0000, 1, 4'b0011, {8'h88, 8'hC2, 8'hE1, 8'hE0}, 12));
    vecs.push_back(mk(0, 1, 2, 8'hE2, 4'b0000, 1, 4'b0111, {8'h88, 8'hE2, 8'hE1, 8'hE0}, 13));
    vecs.push_back(mk(0, 1, 3, 8'hE3, 4'b0000, 1, 4'b1111, {8'hE3, 8'hE2, 8'hE1, 8'hE0}, 14));
    vecs.push_back(mk(1, 1, 0, 8'hF0, 4'b0000, 0, 4'b0000, {8'h00, 8'h00, 8'h00, 8'h00}, 0));
    vecs.push_back(mk(0, 1, 0, 8'h11, 4'b0000, 1, 4'b0001, {8'h00, 8'h00, 8'h00, 8'h11}, 1));
    vecs.push_back(mk(0, 0, 0, 8'h00, 4'b0001, 1, 4'b0000, {8'h00, 8'h00, 8'h00, 8'h11}, 1));

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // Counter wrap: reset, then 17 back-to-back words with every consumer
    // ready. Each word must appear on its channel one edge after acceptance.
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; out_ready = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 17; k++) begin
      logic [7:0] w;
      logic [1:0] ch;
      w  = 8'(8'h30 + k);
      ch = 2'(k % 4);
      @(negedge clk);
      in_valid = 1'b1; sel = ch; din = w;
      @(posedge clk);
      #1;
      checkOutput($sformatf("wrap%0d dout", k), {24'd0, dout_all[ch]}, {24'd0, w});
      checkOutput($sformatf("wrap%0d out_valid", k), {28'd0, out_valid}, {28'd0, 4'(1 << ch)});
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("wrap xfer_cnt", {16'd0, xfer_cnt}, 32'd17);
    checkOutput("wrap xfer_cnt_n", {28'd0, xfer_cnt_n}, 32'd1);
    checkOutput("wrap out_valid", {28'd0, out_valid}, 32'd0);
    checkOutput("wrap busy", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule : tb_demux4_stream
